muldiv: RTL and testbench

Iterative multiply/divide unit of the multi-cycle MIPS core; sits in the execute stage beside the ALU, fed by the same register-file operands (A = rs, B = rt). It executes MULT, MULTU, DIV, DIVU into the architectural HI/LO registers and services MTHI/MTLO. HI/LO feed the write-back mux for MFHI/MFLO. `busy` stalls the control FSM while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv.sv | 130 +++++++++++++
 tb/tb_muldiv.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the per-operation flags latched at start.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // neg_q covers both the product and the quotient sign; neg_r is the remainder sign.
  typedef struct packed {
    logic div;
    logic neg_q;
    logic neg_r;
    logic dz;
  } md_flags_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and the
// final sign correction of product, quotient and remainder.
module md_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? -a : a;

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Sign-magnitude datapath: magnitudes in, WIDTH iterations, one sign-fix cycle.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  md_state_e            state, state_nxt;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     opnd;
  md_flags_t            flg;

  logic                 op_arith, op_sgn, op_div;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign op_arith = ~MDOp[2];
  assign op_sgn   = op_arith & ~MDOp[0];
  assign op_div   = op_arith & MDOp[1];

  md_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(op_sgn & A[WIDTH-1]), .a(A), .y(a_mag));
  md_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(op_sgn & B[WIDTH-1]), .a(B), .y(b_mag));

  // acc holds {partial product, multiplier} for mul, and the dividend/quotient
  // shift register in its low half for div. opnd is the multiplicand or divisor.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = {rem, acc[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd};
  end

  md_negate #(.WIDTH(2*WIDTH)) u_neg_p (.neg(flg.neg_q), .a(acc),             .y(prod_fix));
  md_negate #(.WIDTH(WIDTH))   u_neg_q (.neg(flg.neg_q), .a(acc[WIDTH-1:0]),  .y(quo_fix));
  md_negate #(.WIDTH(WIDTH))   u_neg_r (.neg(flg.neg_r), .a(rem),             .y(rem_fix));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start && op_arith) state_nxt = MD_CALC;
      MD_CALC: if (cnt == LAST)       state_nxt = MD_FIX;
      MD_FIX:                         state_nxt = MD_IDLE;
      default:                        state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != MD_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      acc  <= '0;
      rem  <= '0;
      opnd <= '0;
      flg  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          if (op_arith) begin
            cnt       <= '0;
            rem       <= '0;
            flg.div   <= op_div;
            flg.neg_q <= op_sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
            flg.neg_r <= op_sgn & op_div & A[WIDTH-1];
            flg.dz    <= op_div & (B == '0);
            if (op_div) begin
              opnd <= b_mag;
              acc  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              opnd <= a_mag;
              acc  <= {{WIDTH{1'b0}}, b_mag};
            end
          end else if (MDOp == MD_MTHI) begin
            HI <= A;
          end else if (MDOp == MD_MTLO) begin
            LO <= A;
          end
        end
        MD_CALC: begin
          cnt <= cnt + 6'd1;
          if (flg.div) begin
            // Restoring step: keep the trial difference only when it did not borrow.
            rem             <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], ~rem_diff[WIDTH]};
          end else begin
            acc <= mul_nxt;
          end
        end
        MD_FIX: begin
          if (flg.div) begin
            // Remainder of a zero divide is |A| re-signed, i.e. A itself.
            HI <= rem_fix;
            LO <= flg.dz ? '1 : quo_fix;
          end else begin
            {HI, LO} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: stimulus pushes expected HI/LO, a monitor pops
// on each completed operation and checks values, latency and HI/LO hold.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic        bprev = 1'b0;
  logic        track = 1'b0;
  logic        hold_ok;
  int          lat;
  logic [31:0] h0, l0;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MDOp(MDOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    start = 1'b1; MDOp = op; A = a; B = b;
    q.push_back('{hi: ehi, lo: elo, nm: nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", nm, n);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : mon
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        bprev = 1'b0;
        track = 1'b0;
        continue;
      end
      if (start && !bprev) begin
        if (MDOp[2]) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: got MT completion, expected none");
          end else begin
            e = q.pop_front();
            chk({e.nm, "_hi"}, HI, e.hi);
            chk({e.nm, "_lo"}, LO, e.lo);
            chk({e.nm, "_busy"}, 32'(busy), 0);
          end
        end else begin
          chk("busy_rise", 32'(busy), 1);
          track = 1'b1; lat = 0; h0 = HI; l0 = LO; hold_ok = 1'b1;
        end
      end else if (track) begin
        lat++;
        if (busy) begin
          if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
        end else begin
          track = 1'b0;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow: got completion, expected none");
          end else begin
            e = q.pop_front();
            chk({e.nm, "_hi"}, HI, e.hi);
            chk({e.nm, "_lo"}, LO, e.lo);
            chk({e.nm, "_lat"}, 32'(lat), 33);
            chk({e.nm, "_hold"}, 32'(hold_ok), 1);
          end
        end
      end
      bprev = busy;
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; MDOp = MD_MULT; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    rst = 1'b1;
    @(negedge clk);

    issue("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done("mult_m3x5");
    // Back-to-back: each issue lands in the first cycle busy reads 0.
    issue("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max");
    issue("mult_m1m1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
    wait_done("mult_m1m1");
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("divu_100_7");
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_m7_2");
    issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    wait_done("div_7_m2");
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_done("div_ovf");

    issue("div_by_0", MD_DIV, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    start = 1'b1; MDOp = MD_MULTU; A = 32'd1; B = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done("div_by_0");

    issue("mthi", MD_MTHI, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    issue("mtlo", MD_MTLO, 32'h0000_0001, 32'h0, 32'hDEAD_BEEF, 32'h0000_0001);
    @(negedge clk);
    chk("mt_busy_after", 32'(busy), 0);

    // Abort a DIVU at CALC cycle 10; nothing is pushed for it.
    start = 1'b1; MDOp = MD_DIVU; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue("multu_3x4", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
    wait_done("multu_3x4");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    chk("sb_idle", 32'(track), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
